conv_out_packer: RTL

//  Downstream stage of the conv Control/PE array. Takes 25-bit signed PE results one per handshake,

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_requant.sv | 48 ++++
 rtl/conv_out_packer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : conv_pkg                                               |
// | Shared widths, int8 limits and packer state encoding for the     |
// | conv output path.                                                |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package conv_pkg;

  localparam int PSUM_W = 25;
  localparam int WORD_B = 8;

  localparam logic signed [7:0] c_INT8_MAX = 8'sh7f;
  localparam logic signed [7:0] c_INT8_MIN = 8'sh80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } packer_state_t;

endpackage
`default_nettype wire

// File: rtl/conv_requant.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : conv_requant                                           |
// | Combinational requantizer: rounding right shift, optional ReLU,  |
// | saturation of a signed partial sum to int8.                      |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module conv_requant #(
  parameter int PSUM_W = conv_pkg::PSUM_W
) (
  input  logic signed [PSUM_W-1:0] i_psum,
  input  logic        [4:0]        i_shift,
  input  logic                     i_relu,
  output logic        [7:0]        o_q
);

  // One extra bit of headroom so adding the rounding half never overflows.
  logic signed [PSUM_W:0] w_round;
  logic signed [PSUM_W:0] w_sum;
  logic signed [PSUM_W:0] w_q;
  logic signed [PSUM_W:0] w_max;
  logic signed [PSUM_W:0] w_min;

  assign w_max = (PSUM_W+1)'(conv_pkg::c_INT8_MAX);
  assign w_min = (PSUM_W+1)'(conv_pkg::c_INT8_MIN);

  // Round-half-up shift, clamp negatives under ReLU, then saturate to int8.
  always_comb begin
    w_round = '0;
    if (i_shift != 5'd0) begin
      w_round[i_shift - 5'd1] = 1'b1;
    end
    w_sum = $signed({i_psum[PSUM_W-1], i_psum}) + w_round;
    w_q   = w_sum >>> i_shift;
    if (i_relu && (w_q < $signed(0))) begin
      w_q = '0;
    end
    if (w_q > w_max) begin
      o_q = conv_pkg::c_INT8_MAX;
    end else if (w_q < w_min) begin
      o_q = conv_pkg::c_INT8_MIN;
    end else begin
      o_q = w_q[7:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_out_packer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : conv_out_packer                                        |
// | Requantizes PE results to int8, packs them little-endian into    |
// | output words and streams the words out with incrementing address |
// | and an end-of-layer pulse.                                       |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module conv_out_packer #(
  parameter int PSUM_W = conv_pkg::PSUM_W,
  parameter int WORD_B = conv_pkg::WORD_B,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic        [4:0]        cfg_shift,
  input  logic                     cfg_relu,
  input  logic        [15:0]       cfg_num_pix,
  input  logic                     psum_valid,
  output logic                     psum_ready,
  input  logic signed [PSUM_W-1:0] psum_data,
  output logic                     write_o,
  input  logic                     o_ready,
  output logic        [8*WORD_B-1:0] Odata,
  output logic        [ADDR_W-1:0] o_addr,
  output logic                     o_last,
  output logic                     busy,
  output logic                     end_conv
);

  import conv_pkg::*;

  localparam int DATA_W = 8 * WORD_B;
  localparam int CNT_W  = $clog2(WORD_B);

  packer_state_t     r_state;
  packer_state_t     w_next_state;
  logic [4:0]        r_shift;
  logic              r_relu;
  logic [15:0]       r_num_pix;
  logic [15:0]       r_pix_cnt;
  logic [CNT_W-1:0]  r_byte_cnt;
  logic [DATA_W-1:0] r_pack;
  logic [DATA_W-1:0] r_odata;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_next_addr;
  logic              r_write;
  logic              r_last;

  logic [7:0]        w_byte;
  logic [DATA_W-1:0] w_word;
  logic              w_is_last;
  logic              w_word_done;
  logic              w_out_free;
  logic              w_ready;
  logic              w_accept;

  conv_requant #(
    .PSUM_W (PSUM_W)
  ) u_requant (
    .i_psum  (psum_data),
    .i_shift (r_shift),
    .i_relu  (r_relu),
    .o_q     (w_byte)
  );

  // A byte that completes a word goes straight into the output register,
  // so it may only be taken when that register is empty or draining now.
  assign w_is_last   = (r_pix_cnt == (r_num_pix - 16'd1));
  assign w_word_done = (r_byte_cnt == CNT_W'(WORD_B - 1)) || w_is_last;
  assign w_out_free  = !r_write || o_ready;
  assign w_ready     = (r_state == ST_RUN) && (!w_word_done || w_out_free);
  assign w_accept    = psum_valid && w_ready;
  assign w_word      = r_pack | (DATA_W'(w_byte) << {r_byte_cnt, 3'b000});

  assign psum_ready = w_ready;
  assign write_o    = r_write;
  assign Odata      = r_odata;
  assign o_addr     = r_addr;
  assign o_last     = r_last && r_write;
  assign busy       = (r_state != ST_IDLE);
  assign end_conv   = (r_state == ST_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Layer sequencing: run until the last result, flush the final word, pulse done.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (cfg_num_pix == 16'd0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_accept && w_is_last) begin
          w_next_state = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (r_write && o_ready) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Config latch, pixel/byte counters, pack register and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_num_pix   <= '0;
      r_pix_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_pack      <= '0;
      r_odata     <= '0;
      r_addr      <= '0;
      r_next_addr <= '0;
      r_write     <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_shift     <= cfg_shift;
        r_relu      <= cfg_relu;
        r_num_pix   <= cfg_num_pix;
        r_pix_cnt   <= '0;
        r_byte_cnt  <= '0;
        r_pack      <= '0;
        r_next_addr <= '0;
      end
      if (r_write && o_ready) begin
        r_write <= 1'b0;
      end
      if (w_accept) begin
        r_pix_cnt <= r_pix_cnt + 16'd1;
        if (w_word_done) begin
          r_pack      <= '0;
          r_byte_cnt  <= '0;
          r_write     <= 1'b1;
          r_odata     <= w_word;
          r_addr      <= r_next_addr;
          r_next_addr <= r_next_addr + ADDR_W'(1);
          r_last      <= w_is_last;
        end else begin
          r_pack     <= w_word;
          r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire
